// File: rtl/hwpe_ctrl_ctx_scheduler_pkg.sv
// hwpe_ctrl_package: shared control typedefs for the job-context scheduler and regfile flags
package hwpe_ctrl_package;

    typedef enum logic [1:0] {
        GRANT    = 2'd0,
        CRITICAL = 2'd1,
        FULL     = 2'd2
    } acq_resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } ctx_sched_state_t;

    // Flags exposed through the register file; context fields sized for up to 4 contexts
    typedef struct packed {
        logic       is_critical;
        logic [1:0] pointer_context;
        logic [1:0] running_context;
        logic       full_context;
        logic       true_done;
    } flags_regfile_t;

    // Context index width, never narrower than one bit
    function automatic int ctx_log2(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hwpe_ctrl_ctx_scheduler_if.sv
// hwpe_ctrl_ctx_scheduler_if: requester/engine handshake bundle for the context scheduler
interface hwpe_ctrl_ctx_scheduler_if
    import hwpe_ctrl_package::*;
#(
    parameter int N_CONTEXT = 2,
    parameter int ID_WIDTH  = 16
);
    localparam int LOG_CONTEXT = ctx_log2(N_CONTEXT);

    logic                   clear_i;
    logic                   acquire_i;
    logic [ID_WIDTH-1:0]    acquire_src_i;
    logic                   trigger_i;
    logic [ID_WIDTH-1:0]    trigger_src_i;
    logic                   done_i;
    logic                   acq_valid_o;
    acq_resp_t              acq_resp_o;
    logic                   start_o;
    logic [LOG_CONTEXT-1:0] pointer_context_o;
    logic [LOG_CONTEXT-1:0] running_context_o;
    logic                   full_context_o;
    logic                   is_critical_o;
    logic                   true_done_o;
    logic                   busy_o;
    logic                   trig_err_o;

    modport master (
        output clear_i, acquire_i, acquire_src_i, trigger_i, trigger_src_i, done_i,
        input  acq_valid_o, acq_resp_o, start_o, pointer_context_o, running_context_o,
               full_context_o, is_critical_o, true_done_o, busy_o, trig_err_o
    );

    modport slave (
        input  clear_i, acquire_i, acquire_src_i, trigger_i, trigger_src_i, done_i,
        output acq_valid_o, acq_resp_o, start_o, pointer_context_o, running_context_o,
               full_context_o, is_critical_o, true_done_o, busy_o, trig_err_o
    );

endinterface

// File: rtl/hwpe_ctrl_ctx_scheduler.sv
// hwpe_ctrl_ctx_scheduler: programming-lock arbiter and job queue sequencing engine start/done
module hwpe_ctrl_ctx_scheduler
    import hwpe_ctrl_package::*;
#(
    parameter int N_CONTEXT = 2,
    parameter int ID_WIDTH  = 16
)(
    input  logic clk_i,
    input  logic rst_ni,
    hwpe_ctrl_ctx_scheduler_if.slave bus
);
    localparam int LOG_CONTEXT = ctx_log2(N_CONTEXT);
    localparam int CW          = LOG_CONTEXT + 1;

    ctx_sched_state_t       r_state;
    logic [CW-1:0]          r_cnt;
    logic [LOG_CONTEXT-1:0] r_ptr;
    logic [LOG_CONTEXT-1:0] r_run;
    logic [ID_WIDTH-1:0]    r_owner;
    logic                   r_critical;
    logic                   r_acq_valid;
    acq_resp_t              r_acq_resp;
    logic                   r_start;
    logic                   r_true_done;
    logic                   r_trig_err;

    logic w_full;
    logic w_grant;
    logic w_trig_ok;
    logic w_dec;

    assign w_full    = (r_cnt == CW'(N_CONTEXT));
    assign w_grant   = bus.acquire_i & ~r_critical & ~w_full;
    assign w_trig_ok = bus.trigger_i & r_critical & (bus.trigger_src_i == r_owner);
    assign w_dec     = (r_state == DONE);

    // Acquire responses, lock ownership, programming pointer and trigger errors
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acq_valid <= 1'b0;
            r_acq_resp  <= GRANT;
            r_critical  <= 1'b0;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_trig_err  <= 1'b0;
        end else if (bus.clear_i) begin
            r_acq_valid <= 1'b0;
            r_acq_resp  <= GRANT;
            r_critical  <= 1'b0;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_trig_err  <= 1'b0;
        end else begin
            r_acq_valid <= bus.acquire_i;
            r_trig_err  <= bus.trigger_i & ~w_trig_ok;
            if (bus.acquire_i)
                r_acq_resp <= r_critical ? CRITICAL : (w_full ? FULL : GRANT);
            if (w_grant) begin
                r_critical <= 1'b1;
                r_owner    <= bus.acquire_src_i;
            end else if (w_trig_ok) begin
                r_critical <= 1'b0;
                r_ptr      <= r_ptr + LOG_CONTEXT'(1);
            end
        end
    end

    // Job counter and engine FSM; start/true_done are registered alongside the state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_run       <= '0;
            r_start     <= 1'b0;
            r_true_done <= 1'b0;
        end else if (bus.clear_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_run       <= '0;
            r_start     <= 1'b0;
            r_true_done <= 1'b0;
        end else begin
            r_cnt <= r_cnt + CW'(w_trig_ok) - CW'(w_dec);
            case (r_state)
                IDLE: if (r_cnt != '0) begin
                    r_state <= START;
                    r_start <= 1'b1;
                end
                START: begin
                    r_state <= RUN;
                    r_start <= 1'b0;
                end
                RUN: if (bus.done_i) begin
                    r_state     <= DONE;
                    r_true_done <= 1'b1;
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_true_done <= 1'b0;
                    r_run       <= r_run + LOG_CONTEXT'(1);
                end
            endcase
        end
    end

    assign bus.acq_valid_o       = r_acq_valid;
    assign bus.acq_resp_o        = r_acq_resp;
    assign bus.start_o           = r_start;
    assign bus.pointer_context_o = r_ptr;
    assign bus.running_context_o = r_run;
    assign bus.full_context_o    = w_full;
    assign bus.is_critical_o     = r_critical;
    assign bus.true_done_o       = r_true_done;
    assign bus.busy_o            = (r_cnt != '0) | (r_state != IDLE);
    assign bus.trig_err_o        = r_trig_err;

endmodule

// File: tb/tb_hwpe_ctrl_ctx_scheduler.sv
// tb_hwpe_ctrl_ctx_scheduler: directed self-checking bench for the context scheduler
module tb_hwpe_ctrl_ctx_scheduler;
    import hwpe_ctrl_package::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    hwpe_ctrl_ctx_scheduler_if #(.N_CONTEXT(2), .ID_WIDTH(16)) bus ();

    hwpe_ctrl_ctx_scheduler #(.N_CONTEXT(2), .ID_WIDTH(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.clear_i       = 1'b0;
        bus.acquire_i     = 1'b0;
        bus.acquire_src_i = '0;
        bus.trigger_i     = 1'b0;
        bus.trigger_src_i = '0;
        bus.done_i        = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        chk("rst_acq_valid", 32'(bus.acq_valid_o), 0);
        chk("rst_acq_resp", 32'(bus.acq_resp_o), 32'(GRANT));
        chk("rst_start", 32'(bus.start_o), 0);
        chk("rst_ptr", 32'(bus.pointer_context_o), 0);
        chk("rst_run", 32'(bus.running_context_o), 0);
        chk("rst_full", 32'(bus.full_context_o), 0);
        chk("rst_crit", 32'(bus.is_critical_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_trig_err", 32'(bus.trig_err_o), 0);
        rst_n = 1'b1;
        step();

        bus.acquire_i = 1'b1; bus.acquire_src_i = 16'd3;
        step();
        chk("acq1_valid", 32'(bus.acq_valid_o), 1);
        chk("acq1_grant", 32'(bus.acq_resp_o), 32'(GRANT));
        chk("acq1_crit", 32'(bus.is_critical_o), 1);
        bus.acquire_src_i = 16'd5;
        step();
        chk("acq2_critical", 32'(bus.acq_resp_o), 32'(CRITICAL));
        bus.acquire_i = 1'b0;
        step();
        chk("acq_valid_drop", 32'(bus.acq_valid_o), 0);

        bus.trigger_i = 1'b1; bus.trigger_src_i = 16'd5;
        step();
        chk("bad_trig_err", 32'(bus.trig_err_o), 1);
        chk("bad_trig_crit", 32'(bus.is_critical_o), 1);
        chk("bad_trig_cnt", 32'(dut.r_cnt), 0);
        chk("bad_trig_ptr", 32'(bus.pointer_context_o), 0);
        bus.trigger_src_i = 16'd3;
        step();
        chk("trig1_err", 32'(bus.trig_err_o), 0);
        chk("trig1_crit", 32'(bus.is_critical_o), 0);
        chk("trig1_cnt", 32'(dut.r_cnt), 1);
        chk("trig1_ptr", 32'(bus.pointer_context_o), 1);
        chk("trig1_busy", 32'(bus.busy_o), 1);
        bus.trigger_i = 1'b0;
        bus.acquire_i = 1'b1; bus.acquire_src_i = 16'd3;
        step();
        chk("acq3_grant", 32'(bus.acq_resp_o), 32'(GRANT));
        chk("job1_start", 32'(bus.start_o), 1);
        bus.acquire_i = 1'b0;
        bus.trigger_i = 1'b1; bus.trigger_src_i = 16'd3;
        step();
        chk("trig2_cnt", 32'(dut.r_cnt), 2);
        chk("trig2_full", 32'(bus.full_context_o), 1);
        chk("trig2_ptr_wrap", 32'(bus.pointer_context_o), 0);
        chk("job1_start_off", 32'(bus.start_o), 0);
        bus.trigger_i = 1'b0;
        bus.acquire_i = 1'b1; bus.acquire_src_i = 16'd7;
        step();
        chk("acq4_valid", 32'(bus.acq_valid_o), 1);
        chk("acq4_full", 32'(bus.acq_resp_o), 32'(FULL));
        chk("acq4_crit", 32'(bus.is_critical_o), 0);
        bus.acquire_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("run_no_start", 32'(bus.start_o), 0);
        chk("run_busy", 32'(bus.busy_o), 1);
        bus.done_i = 1'b1;
        step();
        chk("job1_true_done", 32'(bus.true_done_o), 1);
        chk("job1_run_hold", 32'(bus.running_context_o), 0);
        bus.done_i = 1'b0;
        step();
        chk("job1_td_off", 32'(bus.true_done_o), 0);
        chk("job1_run_adv", 32'(bus.running_context_o), 1);
        chk("job1_cnt", 32'(dut.r_cnt), 1);
        chk("job1_not_full", 32'(bus.full_context_o), 0);
        chk("job2_no_start_yet", 32'(bus.start_o), 0);
        step();
        chk("job2_start", 32'(bus.start_o), 1);
        step();
        chk("job2_start_off", 32'(bus.start_o), 0);

        bus.acquire_i = 1'b1; bus.acquire_src_i = 16'd3;
        step();
        chk("acq5_grant", 32'(bus.acq_resp_o), 32'(GRANT));
        bus.acquire_i = 1'b0;
        bus.done_i = 1'b1;
        step();
        chk("job2_true_done", 32'(bus.true_done_o), 1);
        bus.done_i = 1'b0;
        bus.trigger_i = 1'b1; bus.trigger_src_i = 16'd3;
        step();
        chk("coinc_cnt", 32'(dut.r_cnt), 1);
        chk("coinc_ptr", 32'(bus.pointer_context_o), 1);
        chk("coinc_run", 32'(bus.running_context_o), 0);
        chk("coinc_start_wait", 32'(bus.start_o), 0);
        bus.trigger_i = 1'b0;
        step();
        chk("coinc_start", 32'(bus.start_o), 1);
        step();

        bus.clear_i = 1'b1;
        step();
        bus.clear_i = 1'b0;
        chk("clr_cnt", 32'(dut.r_cnt), 0);
        chk("clr_busy", 32'(bus.busy_o), 0);
        chk("clr_ptr", 32'(bus.pointer_context_o), 0);
        chk("clr_run", 32'(bus.running_context_o), 0);
        chk("clr_crit", 32'(bus.is_critical_o), 0);
        bus.done_i = 1'b1;
        step();
        bus.done_i = 1'b0;
        chk("clr_done_ignored", 32'(bus.true_done_o), 0);
        step();
        chk("clr_done_ignored2", 32'(bus.true_done_o), 0);
        chk("clr_busy2", 32'(bus.busy_o), 0);

        bus.acquire_i = 1'b1; bus.acquire_src_i = 16'd3;
        step();
        chk("acq6_grant", 32'(bus.acq_resp_o), 32'(GRANT));
        bus.acquire_src_i = 16'd4;
        bus.trigger_i = 1'b1; bus.trigger_src_i = 16'd3;
        step();
        chk("same_cycle_critical", 32'(bus.acq_resp_o), 32'(CRITICAL));
        chk("same_cycle_unlock", 32'(bus.is_critical_o), 0);
        chk("same_cycle_cnt", 32'(dut.r_cnt), 1);
        idle_inputs();
        step();
        chk("job3_start", 32'(bus.start_o), 1);
        step();
        chk("job3_start_off", 32'(bus.start_o), 0);
        for (int i = 0; i < 10; i++) step();
        bus.done_i = 1'b1;
        step();
        bus.done_i = 1'b0;
        chk("job3_true_done", 32'(bus.true_done_o), 1);
        step();
        chk("job3_td_off", 32'(bus.true_done_o), 0);
        chk("job3_run", 32'(bus.running_context_o), 1);
        chk("job3_busy", 32'(bus.busy_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
